decode_stage: RTL and testbench

Instruction decode stage sitting between fetch and the register file / execute stage of the ARM-subset pipeline. Accepts one 32-bit instruction per cycle over a valid/ready handshake, drives the synchronous register-file read addresses, and detects read-after-write hazards with a pending-write scoreboard. Registers a decoded bundle for execute, timed so that the register-file read data arrives in the same cycle the bundle becomes valid.

---
 rtl/decode_pkg.sv | 101 ++++++++++
 rtl/decode_scoreboard.sv | 47 ++++
 rtl/decode_stage.sv | 98 +++++++++
 tb/tb_decode_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared encodings, field widths and the instruction decode function for decode_stage.
package decode_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int OPC_W   = 4;
    localparam int SHIFT_W = 7;

    typedef enum logic [1:0] {
        CLS_NOP  = 2'd0,
        CLS_DP   = 2'd1,
        CLS_LDST = 2'd2,
        CLS_BR   = 2'd3
    } cls_e;

    localparam logic [3:0] COND_NV   = 4'hF;
    localparam logic [3:0] OP_CMP_LO = 4'b1000;
    localparam logic [3:0] OP_CMP_HI = 4'b1011;

    localparam logic [ADDR_W-1:0] REG_PC = 4'd15;
    localparam logic [ADDR_W-1:0] REG_LR = 4'd14;

    typedef struct packed {
        cls_e                cls;
        logic [3:0]          cond;
        logic [OPC_W-1:0]    opcode;
        logic                set_flags;
        logic                use_imm;
        logic [DATA_W-1:0]   imm;
        logic [SHIFT_W-1:0]  shift;
        logic                wr_en;
        logic [ADDR_W-1:0]   wr_addr;
        logic [DATA_W-1:0]   pc;
        logic [ADDR_W-1:0]   src1;
        logic [ADDR_W-1:0]   src2;
    } bundle_t;

    typedef struct packed {
        bundle_t b;
        logic    use1;
        logic    use2;
    } dec_t;

    function automatic logic [DATA_W-1:0] ror_imm(input logic [7:0] imm8, input logic [3:0] rot);
        logic [DATA_W-1:0] x;
        logic [5:0]        amt;
        x   = {24'h0, imm8};
        amt = {1'b0, rot, 1'b0};
        return (x >> amt) | (x << (6'd32 - amt));
    endfunction

    function automatic dec_t decode_instr(input logic [31:0] instr, input logic [DATA_W-1:0] pc);
        dec_t d;
        d        = '0;
        d.b.pc   = pc;
        d.b.cond = instr[31:28];
        if (instr[31:28] != COND_NV) begin
            case (instr[27:26])
                2'b00: begin
                    d.b.cls       = CLS_DP;
                    d.b.opcode    = instr[24:21];
                    d.b.set_flags = instr[20];
                    d.b.use_imm   = instr[25];
                    d.b.imm       = ror_imm(instr[7:0], instr[11:8]);
                    d.b.shift     = {instr[6:5], instr[11:7]};
                    d.b.wr_en     = !(instr[24:21] >= OP_CMP_LO && instr[24:21] <= OP_CMP_HI);
                    d.b.wr_addr   = instr[15:12];
                    d.b.src1      = instr[19:16];
                    d.b.src2      = instr[3:0];
                    d.use1        = 1'b1;
                    d.use2        = !instr[25];
                end
                2'b01: begin
                    d.b.cls       = CLS_LDST;
                    d.b.opcode    = instr[24:21];
                    d.b.set_flags = instr[20];
                    d.b.use_imm   = !instr[25];
                    d.b.imm       = {20'h0, instr[11:0]};
                    d.b.shift     = {instr[6:5], instr[11:7]};
                    d.b.wr_en     = instr[20];
                    d.b.wr_addr   = instr[15:12];
                    d.b.src1      = instr[19:16];
                    d.b.src2      = instr[15:12];
                    d.use1        = 1'b1;
                    // Stores read Rd as data even in immediate-offset form.
                    d.use2        = instr[25] || !instr[20];
                end
                2'b10: begin
                    d.b.cls     = CLS_BR;
                    d.b.use_imm = 1'b1;
                    d.b.imm     = {{6{instr[23]}}, instr[23:0], 2'b00};
                    d.b.wr_en   = instr[24];
                    d.b.wr_addr = REG_LR;
                end
                default: d.b.cls = CLS_NOP;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Pending-write bits for R0-R14 with two hazard query ports; R15 is never tracked.
// DECODE_BYPASS_EN lets a same-cycle writeback mask a query hit.
module decode_scoreboard
    import decode_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic              flush_clr_en_i,
    input  logic [ADDR_W-1:0] flush_clr_addr_i,
    input  logic              q1_en_i,
    input  logic [ADDR_W-1:0] q1_addr_i,
    input  logic              q2_en_i,
    input  logic [ADDR_W-1:0] q2_addr_i,
    output logic              hz1_o,
    output logic              hz2_o
);

    logic [14:0] pend_q, pend_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    // Set is applied last so it wins over a clear to the same register.
    always_comb begin
        pend_d = pend_q;
        if (clr_en_i && clr_addr_i != REG_PC)             pend_d[clr_addr_i]       = 1'b0;
        if (flush_clr_en_i && flush_clr_addr_i != REG_PC) pend_d[flush_clr_addr_i] = 1'b0;
        if (set_en_i && set_addr_i != REG_PC)             pend_d[set_addr_i]       = 1'b1;
    end

    always_comb begin
        hz1_o = q1_en_i && q1_addr_i != REG_PC && pend_q[q1_addr_i];
        hz2_o = q2_en_i && q2_addr_i != REG_PC && pend_q[q2_addr_i];
`ifdef DECODE_BYPASS_EN
        if (clr_en_i && clr_addr_i == q1_addr_i) hz1_o = 1'b0;
        if (clr_en_i && clr_addr_i == q2_addr_i) hz2_o = 1'b0;
`else
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode with pending-write hazard stall and a registered bundle (latency 1).
// Optional DECODE_BYPASS_EN: a writeback in the same cycle releases a hazard without waiting for the edge.
module decode_stage
    import decode_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        instr_i,
    input  logic [DATA_W-1:0]  pc_i,
    input  logic               instr_valid_i,
    output logic               instr_ready_o,
    output logic [ADDR_W-1:0]  r1_addr_o,
    output logic [ADDR_W-1:0]  r2_addr_o,
    output logic               ex_valid_o,
    input  logic               ex_ready_i,
    output logic [1:0]         ex_class_o,
    output logic [3:0]         ex_cond_o,
    output logic [OPC_W-1:0]   ex_opcode_o,
    output logic               ex_set_flags_o,
    output logic               ex_use_imm_o,
    output logic [DATA_W-1:0]  ex_imm_o,
    output logic [SHIFT_W-1:0] ex_shift_o,
    output logic               ex_wr_en_o,
    output logic [ADDR_W-1:0]  ex_wr_addr_o,
    output logic [DATA_W-1:0]  ex_pc_o,
    input  logic               wb_en_i,
    input  logic [ADDR_W-1:0]  wb_addr_i,
    input  logic               flush_i
);

    dec_t    dec;
    bundle_t bnd_q, bnd_d;
    logic    ex_valid_q, ex_valid_d;
    logic    hz1, hz2, hold, accept;

    always_comb dec = decode_instr(instr_i, pc_i);

    decode_scoreboard u_scoreboard (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .set_en_i         (accept && dec.b.wr_en),
        .set_addr_i       (dec.b.wr_addr),
        .clr_en_i         (wb_en_i),
        .clr_addr_i       (wb_addr_i),
        .flush_clr_en_i   (flush_i && ex_valid_q && bnd_q.wr_en),
        .flush_clr_addr_i (bnd_q.wr_addr),
        .q1_en_i          (dec.use1),
        .q1_addr_i        (dec.b.src1),
        .q2_en_i          (dec.use2),
        .q2_addr_i        (dec.b.src2),
        .hz1_o            (hz1),
        .hz2_o            (hz2)
    );

    assign hold          = ex_valid_q && !ex_ready_i;
    assign instr_ready_o = !rst_i && !flush_i && !hz1 && !hz2 && !hold;
    assign accept        = instr_valid_i && instr_ready_o;

    // Holding the bundle's sources makes the register file re-read them, picking up late writebacks.
    assign r1_addr_o = rst_i ? '0 : (hold ? bnd_q.src1 : dec.b.src1);
    assign r2_addr_o = rst_i ? '0 : (hold ? bnd_q.src2 : dec.b.src2);

    always_comb begin
        ex_valid_d = ex_valid_q;
        bnd_d      = bnd_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            bnd_d      = dec.b;
        end else if (ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_q <= 1'b0;
            bnd_q      <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            bnd_q      <= bnd_d;
        end
    end

    assign ex_valid_o     = ex_valid_q;
    assign ex_class_o     = bnd_q.cls;
    assign ex_cond_o      = bnd_q.cond;
    assign ex_opcode_o    = bnd_q.opcode;
    assign ex_set_flags_o = bnd_q.set_flags;
    assign ex_use_imm_o   = bnd_q.use_imm;
    assign ex_imm_o       = bnd_q.imm;
    assign ex_shift_o     = bnd_q.shift;
    assign ex_wr_en_o     = bnd_q.wr_en;
    assign ex_wr_addr_o   = bnd_q.wr_addr;
    assign ex_pc_o        = bnd_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, corner-case sequences, random vs reference model.
`timescale 1ns/1ps
module tb_decode_stage;

`ifdef DECODE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc;
    logic        instr_valid, instr_ready;
    logic [3:0]  r1_addr, r2_addr;
    logic        ex_valid, ex_ready;
    logic [1:0]  ex_class;
    logic [3:0]  ex_cond, ex_opcode;
    logic        ex_set_flags, ex_use_imm;
    logic [31:0] ex_imm;
    logic [6:0]  ex_shift;
    logic        ex_wr_en;
    logic [3:0]  ex_wr_addr;
    logic [31:0] ex_pc;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic        flush;

    decode_stage dut (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .pc_i(pc),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .r1_addr_o(r1_addr), .r2_addr_o(r2_addr),
        .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
        .ex_class_o(ex_class), .ex_cond_o(ex_cond), .ex_opcode_o(ex_opcode),
        .ex_set_flags_o(ex_set_flags), .ex_use_imm_o(ex_use_imm), .ex_imm_o(ex_imm),
        .ex_shift_o(ex_shift), .ex_wr_en_o(ex_wr_en), .ex_wr_addr_o(ex_wr_addr),
        .ex_pc_o(ex_pc), .wb_en_i(wb_en), .wb_addr_i(wb_addr), .flush_i(flush)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  cls;
        logic [3:0]  cond;
        logic [3:0]  op;
        logic        sf;
        logic        ui;
        logic [31:0] imm;
        logic [6:0]  sh;
        logic        wen;
        logic [3:0]  wa;
        logic [31:0] pc;
    } fields_t;

    typedef struct {
        fields_t f;
        int      s1;
        int      s2;
        bit      u1;
        bit      u2;
    } mdec_t;

    typedef struct {
        logic [31:0] ins;
        logic [1:0]  cls;
        logic [3:0]  op;
        logic        ui;
        logic [31:0] imm;
        logic        wen;
        logic [3:0]  wa;
        logic [3:0]  r1;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic fields_t dut_fields();
        return {ex_class, ex_cond, ex_opcode, ex_set_flags, ex_use_imm, ex_imm,
                ex_shift, ex_wr_en, ex_wr_addr, ex_pc};
    endfunction

    // Reference decode computed straight from the instruction-set rules.
    function automatic mdec_t ref_decode(input logic [31:0] ins, input logic [31:0] p);
        mdec_t       m;
        int          kind, rot, off;
        logic [31:0] v;
        m.f = '0; m.s1 = 0; m.s2 = 0; m.u1 = 0; m.u2 = 0;
        m.f.pc   = p;
        m.f.cond = ins[31:28];
        kind = (ins[31:28] == 4'hF) ? 3 : int'(ins[27:26]);
        if (kind == 0) begin
            rot = 2 * int'(ins[11:8]);
            v = {24'd0, ins[7:0]};
            m.f.imm = (rot == 0) ? v : ((v >> rot) | (v << (32 - rot)));
            m.f.cls = 2'd1; m.f.op = ins[24:21]; m.f.sf = ins[20]; m.f.ui = ins[25];
            m.f.sh = {ins[6:5], ins[11:7]};
            m.f.wen = !(ins[24:21] inside {[4'd8:4'd11]});
            m.f.wa = ins[15:12];
            m.s1 = int'(ins[19:16]); m.s2 = int'(ins[3:0]);
            m.u1 = 1; m.u2 = !ins[25];
        end else if (kind == 1) begin
            m.f.cls = 2'd2; m.f.op = ins[24:21]; m.f.sf = ins[20]; m.f.ui = !ins[25];
            m.f.imm = {20'd0, ins[11:0]};
            m.f.sh = {ins[6:5], ins[11:7]};
            m.f.wen = ins[20]; m.f.wa = ins[15:12];
            m.s1 = int'(ins[19:16]); m.s2 = int'(ins[15:12]);
            m.u1 = 1; m.u2 = ins[25] || !ins[20];
        end else if (kind == 2) begin
            off = int'({ins[23:0], 8'h00}) >>> 6;
            m.f.cls = 2'd3; m.f.ui = 1; m.f.imm = off;
            m.f.wen = ins[24]; m.f.wa = 4'd14;
        end
        return m;
    endfunction

    bit    m_pend[16];
    bit    m_valid;
    mdec_t m_bnd;

    function automatic bit ref_busy(input int r, input logic wbe, input logic [3:0] wba);
        return (r != 15) && m_pend[r] && !(BYP && wbe && int'(wba) == r);
    endfunction

    function automatic logic [3:0] pick_reg();
        int r;
        r = $urandom_range(0, 6);
        return (r == 6) ? 4'd15 : (r == 5) ? 4'd14 : 4'(r);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        i = $urandom;
        i[31:28] = ($urandom_range(0, 9) == 0) ? 4'hF : 4'hE;
        i[19:16] = pick_reg();
        i[15:12] = pick_reg();
        i[3:0]   = pick_reg();
        return i;
    endfunction

    task automatic idle_inputs();
        instr = 32'h0; pc = 32'h0; instr_valid = 0; ex_ready = 1;
        wb_en = 0; wb_addr = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic accept_one(input logic [31:0] ins, input logic [31:0] p, input logic rdy, input string tag);
        instr = ins; pc = p; instr_valid = 1; ex_ready = rdy;
        #1 check({tag, " ready"}, instr_ready, 1'b1);
        @(posedge clk); #1;
        instr_valid = 0;
    endtask

    localparam logic [31:0] I_ADD1  = 32'hE2821005;
    localparam logic [31:0] I_LDR4  = 32'hE5914004;
    localparam logic [31:0] I_ADD5  = 32'hE0845004;
    localparam logic [31:0] I_MOV3  = 32'hE3A034FF;
    localparam logic [31:0] I_DEPR1 = 32'hE2812001;

    vec_t vt[9];

    initial begin
        logic [127:0] exp_v, act_v;
        mdec_t d;
        bit hold, haz, exp_rdy, acc;

        vt[0] = '{I_ADD1,       2'd1, 4'h4, 1, 32'h00000005, 1, 4'd1,  4'd2};
        vt[1] = '{I_MOV3,       2'd1, 4'hD, 1, 32'hFF000000, 1, 4'd3,  4'd0};
        vt[2] = '{32'hEAFFFFFE, 2'd3, 4'h0, 1, 32'hFFFFFFF8, 0, 4'd14, 4'd0};
        vt[3] = '{32'hEBFFFFFE, 2'd3, 4'h0, 1, 32'hFFFFFFF8, 1, 4'd14, 4'd0};
        vt[4] = '{I_LDR4,       2'd2, 4'hC, 1, 32'h00000004, 1, 4'd4,  4'd1};
        vt[5] = '{32'hE1520003, 2'd1, 4'hA, 0, 32'h00000003, 0, 4'd0,  4'd2};
        vt[6] = '{32'hE5812008, 2'd2, 4'hC, 1, 32'h00000008, 0, 4'd2,  4'd1};
        vt[7] = '{32'hF2821005, 2'd0, 4'h0, 0, 32'h00000000, 0, 4'd0,  4'd0};
        vt[8] = '{32'hEC000000, 2'd0, 4'h0, 0, 32'h00000000, 0, 4'd0,  4'd0};

        // Reset state, with a live instruction on the input.
        idle_inputs();
        rst = 1; instr = I_ADD1; instr_valid = 1;
        #3;
        check("reset_outputs", {instr_ready, r1_addr, r2_addr, ex_valid, dut_fields()}, '0);
        @(posedge clk); #1 rst = 0; instr_valid = 0;

        for (int k = 0; k < 9; k++) begin
            do_reset();
            instr = vt[k].ins; pc = 32'h1000 + 32'(k * 4); instr_valid = 1; ex_ready = 1;
            #1;
            check($sformatf("vec%0d ready", k), instr_ready, 1'b1);
            check($sformatf("vec%0d r1_addr", k), r1_addr, vt[k].r1);
            @(posedge clk); #1;
            instr_valid = 0;
            check($sformatf("vec%0d ex_valid", k), ex_valid, 1'b1);
            act_v = {ex_class, ex_opcode, ex_use_imm, ex_imm, ex_wr_en, ex_wr_addr};
            exp_v = {vt[k].cls, vt[k].op, vt[k].ui, vt[k].imm, vt[k].wen, vt[k].wa};
            check($sformatf("vec%0d fields", k), act_v, exp_v);
        end

        // ADD R1 leaves R1 pending; a reader of R1 stalls.
        do_reset();
        accept_one(I_ADD1, 32'h0, 1'b1, "add_r1");
        instr = I_DEPR1; instr_valid = 1;
        #1 check("r1_pending_stall", instr_ready, 1'b0);
        wb_en = 1; wb_addr = 4'd1;
        #1 check("r1_wb_cycle", instr_ready, BYP);
        @(posedge clk); #1;
        wb_en = 0; instr_valid = 0;

        // LDR R4 then dependent ADD R5,R4,R4.
        do_reset();
        accept_one(I_LDR4, 32'h40, 1'b1, "ldr");
        instr = I_ADD5; pc = 32'h44; instr_valid = 1;
        for (int c = 0; c < 2; c++) begin
            #1 check($sformatf("ldr_add_stall%0d", c), instr_ready, 1'b0);
            @(posedge clk); #1;
        end
        wb_en = 1; wb_addr = 4'd4;
        #1 check("ldr_add_wb_cycle", instr_ready, BYP);
        @(posedge clk); #1;
        wb_en = 0;
`ifdef DECODE_BYPASS_EN
        instr_valid = 0;
`else
        #1 check("ldr_add_after_wb", instr_ready, 1'b1);
        @(posedge clk); #1;
        instr_valid = 0;
`endif
        check("ldr_add_issued", {ex_valid, ex_wr_addr, ex_pc}, {1'b1, 4'd5, 32'h44});

        // Execute stalls for 3 cycles: bundle and addresses held, nothing dropped.
        do_reset();
        accept_one(I_LDR4, 32'h100, 1'b0, "stall_ldr");
        instr = I_MOV3; pc = 32'h104; instr_valid = 1; ex_ready = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d bundle", c), {ex_valid, ex_pc, ex_wr_addr}, {1'b1, 32'h100, 4'd4});
            check($sformatf("stall%0d addrs", c), {r1_addr, r2_addr}, {4'd1, 4'd4});
            check($sformatf("stall%0d ready", c), instr_ready, 1'b0);
            @(posedge clk); #1;
        end
        ex_ready = 1;
        #1 check("stall_release_ready", instr_ready, 1'b1);
        @(posedge clk); #1;
        instr_valid = 0;
        check("stall_next_bundle", {ex_valid, ex_pc, ex_wr_addr}, {1'b1, 32'h104, 4'd3});

        // Flush the held LDR: bundle dropped and R4 no longer pending.
        do_reset();
        accept_one(I_LDR4, 32'h200, 1'b0, "flush_ldr");
        flush = 1; instr = I_ADD5; instr_valid = 1; ex_ready = 0;
        #1 check("flush_no_accept", instr_ready, 1'b0);
        @(posedge clk); #1;
        flush = 0;
        check("flush_valid", ex_valid, 1'b0);
        #1 check("flush_r4_cleared", instr_ready, 1'b1);
        @(posedge clk); #1;
        instr_valid = 0;

        // Reset asserted mid-stall clears everything at once.
        do_reset();
        accept_one(I_LDR4, 32'h300, 1'b0, "rst_ldr");
        ex_ready = 0; instr = I_MOV3; instr_valid = 1;
        #2 rst = 1;
        #1 check("midstall_reset", {instr_ready, r1_addr, r2_addr, ex_valid, dut_fields()}, '0);
        @(posedge clk); #1;

        // Randomised traffic against the reference model.
        do_reset();
        foreach (m_pend[i]) m_pend[i] = 0;
        m_valid = 0;
        m_bnd = ref_decode(32'h0, 32'h0);
        m_bnd.f = '0;
        for (int c = 0; c < 3000; c++) begin
            instr       = rand_instr();
            pc          = $urandom;
            instr_valid = ($urandom_range(0, 3) != 0);
            ex_ready    = ($urandom_range(0, 2) != 0);
            wb_en       = ($urandom_range(0, 2) == 0);
            wb_addr     = pick_reg();
            flush       = ($urandom_range(0, 15) == 0);
            #1;
            d       = ref_decode(instr, pc);
            hold    = m_valid && !ex_ready;
            haz     = (d.u1 && ref_busy(d.s1, wb_en, wb_addr)) || (d.u2 && ref_busy(d.s2, wb_en, wb_addr));
            exp_rdy = !flush && !haz && !hold;
            check("rand ready", instr_ready, exp_rdy);
            check("rand addrs", {r1_addr, r2_addr},
                  hold ? {4'(m_bnd.s1), 4'(m_bnd.s2)} : {4'(d.s1), 4'(d.s2)});
            acc = instr_valid && exp_rdy;
            if (flush && m_valid && m_bnd.f.wen) m_pend[m_bnd.f.wa] = 0;
            if (wb_en) m_pend[wb_addr] = 0;
            if (acc && d.f.wen) m_pend[d.f.wa] = 1;
            m_pend[15] = 0;
            if (flush)           m_valid = 0;
            else if (acc)        begin m_valid = 1; m_bnd = d; end
            else if (ex_ready)   m_valid = 0;
            @(posedge clk); #1;
            check("rand ex_valid", ex_valid, m_valid);
            if (m_valid) check("rand bundle", dut_fields(), m_bnd.f);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
